// File: rtl/if_fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and instruction memory:
// an address phase (req/addr_ok) followed by a data phase (data_ok/rdata).
interface if_fetch_stage_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    modport master (
        output inst_req,
        output inst_addr,
        input  inst_addr_ok,
        input  inst_data_ok,
        input  inst_rdata
    );

    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_addr_ok,
        output inst_data_ok,
        output inst_rdata
    );
endinterface

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, issues one split-handshake fetch
// at a time and holds the result for IF/ID; responses made stale by a redirect are dropped.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    StallF,
    input  logic                    BranchRedirectD,
    input  logic [31:0]             BranchTargetD,
    input  logic                    ExcRedirect,
    input  logic [31:0]             ExcTarget,
    if_fetch_stage_if.master        imem,
    output logic [31:0]             PCF,
    output logic [31:0]             PCPlus4F,
    output logic [31:0]             ReadDataF,
    output logic                    InstValidF,
    output logic                    AdelF
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_discard;
    logic [31:0] r_pc;
    logic [31:0] r_rdata;
    logic        r_valid;
    logic        r_adel;

    logic        w_redir;
    logic [31:0] w_target;
    logic        w_misaligned;

    assign w_redir      = ExcRedirect | BranchRedirectD;
    assign w_target     = ExcRedirect ? ExcTarget : BranchTargetD;
    assign w_misaligned = (r_pc[1:0] != 2'b00);

    // A misaligned PC never reaches memory; the address error is raised locally.
    assign imem.inst_req  = (r_state == REQ) && !w_misaligned;
    assign imem.inst_addr = r_pc;

    assign PCF        = r_pc;
    assign PCPlus4F   = r_pc + 32'd4;
    assign ReadDataF  = r_rdata;
    assign InstValidF = r_valid;
    assign AdelF      = r_adel;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= BOOT;
            r_discard <= 1'b0;
            r_pc      <= RESET_PC;
            r_rdata   <= '0;
            r_valid   <= 1'b0;
            r_adel    <= 1'b0;
        end else begin
            if (w_redir) begin
                r_pc    <= w_target;
                r_valid <= 1'b0;
                r_adel  <= 1'b0;
            end
            unique case (r_state)
                BOOT: r_state <= REQ;
                REQ: begin
                    if (w_redir) begin
                        // Unaccepted request may retarget freely; an accepted one leaves data owed.
                        if (!w_misaligned && imem.inst_addr_ok) begin
                            r_state   <= WAIT;
                            r_discard <= 1'b1;
                        end
                    end else if (w_misaligned) begin
                        r_state <= HOLD;
                        r_valid <= 1'b1;
                        r_adel  <= 1'b1;
                        r_rdata <= '0;
                    end else if (imem.inst_addr_ok) begin
                        r_state   <= WAIT;
                        r_discard <= 1'b0;
                    end
                end
                WAIT: begin
                    if (imem.inst_data_ok) begin
                        r_discard <= 1'b0;
                        if (r_discard || w_redir) begin
                            r_state <= REQ;
                        end else begin
                            r_rdata <= imem.inst_rdata;
                            r_valid <= 1'b1;
                            r_state <= HOLD;
                        end
                    end else if (w_redir) begin
                        r_discard <= 1'b1;
                    end
                end
                HOLD: begin
                    if (w_redir) begin
                        r_state <= REQ;
                    end else if (!StallF) begin
                        r_pc    <= r_pc + 32'd4;
                        r_valid <= 1'b0;
                        r_adel  <= 1'b0;
                        r_state <= REQ;
                    end
                end
                default: r_state <= BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed cycle-by-cycle bench for if_fetch_stage; the bench plays instruction memory.
module tb_if_fetch_stage;

    logic        clk;
    logic        rst;
    logic        StallF;
    logic        BranchRedirectD;
    logic [31:0] BranchTargetD;
    logic        ExcRedirect;
    logic [31:0] ExcTarget;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;
    logic [31:0] ReadDataF;
    logic        InstValidF;
    logic        AdelF;

    int unsigned n_checks;
    int unsigned n_errors;
    logic        r_saw_stale;

    if_fetch_stage_if bus ();

    if_fetch_stage #(.RESET_PC(32'hBFC0_0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .StallF          (StallF),
        .BranchRedirectD (BranchRedirectD),
        .BranchTargetD   (BranchTargetD),
        .ExcRedirect     (ExcRedirect),
        .ExcTarget       (ExcTarget),
        .imem            (bus.master),
        .PCF             (PCF),
        .PCPlus4F        (PCPlus4F),
        .ReadDataF       (ReadDataF),
        .InstValidF      (InstValidF),
        .AdelF           (AdelF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The squashed word must never be presented as a valid instruction.
    always @(negedge clk) begin
        if (InstValidF && ReadDataF == 32'hDEAD_BEEF) r_saw_stale = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        r_saw_stale = 1'b0;
        rst = 1'b1;
        StallF = 1'b0;
        BranchRedirectD = 1'b0;
        BranchTargetD = '0;
        ExcRedirect = 1'b0;
        ExcTarget = '0;
        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b0;
        bus.inst_rdata = '0;

        tick();
        check("rst_pc", PCF, 32'hBFC0_0000);
        check("rst_pc4", PCPlus4F, 32'hBFC0_0004);
        check("rst_valid", {31'd0, InstValidF}, 32'd0);
        check("rst_adel", {31'd0, AdelF}, 32'd0);
        check("rst_rdata", ReadDataF, 32'd0);
        check("boot_req", {31'd0, bus.inst_req}, 32'd0);

        // Basic single-cycle memory fetch.
        rst = 1'b0;
        tick();
        check("c1_req", {31'd0, bus.inst_req}, 32'd1);
        check("c1_addr", bus.inst_addr, 32'hBFC0_0000);
        bus.inst_addr_ok = 1'b1;
        tick();
        bus.inst_addr_ok = 1'b0;
        check("c2_req", {31'd0, bus.inst_req}, 32'd0);
        check("c2_valid", {31'd0, InstValidF}, 32'd0);
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata = 32'h2408_0001;
        StallF = 1'b1;
        tick();
        bus.inst_data_ok = 1'b0;
        check("c3_valid", {31'd0, InstValidF}, 32'd1);
        check("c3_rdata", ReadDataF, 32'h2408_0001);
        check("c3_pc", PCF, 32'hBFC0_0000);
        check("c3_pc4", PCPlus4F, 32'hBFC0_0004);
        check("c3_adel", {31'd0, AdelF}, 32'd0);

        // Stall in HOLD for four cycles.
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall_valid", {31'd0, InstValidF}, 32'd1);
            check("stall_rdata", ReadDataF, 32'h2408_0001);
            check("stall_pc", PCF, 32'hBFC0_0000);
            check("stall_req", {31'd0, bus.inst_req}, 32'd0);
        end
        StallF = 1'b0;
        tick();
        check("next_req", {31'd0, bus.inst_req}, 32'd1);
        check("next_addr", bus.inst_addr, 32'hBFC0_0004);
        check("next_valid", {31'd0, InstValidF}, 32'd0);

        // Redirect while waiting for data; late response must be dropped.
        bus.inst_addr_ok = 1'b1;
        tick();
        bus.inst_addr_ok = 1'b0;
        BranchRedirectD = 1'b1;
        BranchTargetD = 32'h8000_0100;
        tick();
        BranchRedirectD = 1'b0;
        check("wr_pc", PCF, 32'h8000_0100);
        check("wr_req", {31'd0, bus.inst_req}, 32'd0);
        tick();
        tick();
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata = 32'hDEAD_BEEF;
        tick();
        bus.inst_data_ok = 1'b0;
        check("wr_drop_valid", {31'd0, InstValidF}, 32'd0);
        check("wr_req2", {31'd0, bus.inst_req}, 32'd1);
        check("wr_addr2", bus.inst_addr, 32'h8000_0100);
        bus.inst_addr_ok = 1'b1;
        tick();
        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata = 32'h1111_2222;
        tick();
        bus.inst_data_ok = 1'b0;
        check("wr_new_valid", {31'd0, InstValidF}, 32'd1);
        check("wr_new_rdata", ReadDataF, 32'h1111_2222);
        check("wr_new_pc", PCF, 32'h8000_0100);

        // Exception redirect wins over branch redirect (from HOLD).
        ExcRedirect = 1'b1;
        ExcTarget = 32'hBFC0_0380;
        BranchRedirectD = 1'b1;
        BranchTargetD = 32'h8000_0000;
        tick();
        ExcRedirect = 1'b0;
        BranchRedirectD = 1'b0;
        check("prio_pc", PCF, 32'hBFC0_0380);
        check("prio_addr", bus.inst_addr, 32'hBFC0_0380);
        check("prio_valid", {31'd0, InstValidF}, 32'd0);

        // Misaligned branch target: address error without a memory request.
        BranchRedirectD = 1'b1;
        BranchTargetD = 32'h8000_0102;
        tick();
        BranchRedirectD = 1'b0;
        check("adel_noreq", {31'd0, bus.inst_req}, 32'd0);
        tick();
        check("adel_valid", {31'd0, InstValidF}, 32'd1);
        check("adel_flag", {31'd0, AdelF}, 32'd1);
        check("adel_rdata", ReadDataF, 32'd0);
        check("adel_pc", PCF, 32'h8000_0102);
        check("adel_req_hold", {31'd0, bus.inst_req}, 32'd0);

        // Reset in WAIT; data_ok arriving during BOOT is ignored.
        BranchRedirectD = 1'b1;
        BranchTargetD = 32'h8000_0200;
        tick();
        BranchRedirectD = 1'b0;
        check("pre_rst_adel", {31'd0, AdelF}, 32'd0);
        bus.inst_addr_ok = 1'b1;
        tick();
        bus.inst_addr_ok = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata = 32'hCAFE_F00D;
        check("mrst_pc", PCF, 32'hBFC0_0000);
        check("mrst_valid", {31'd0, InstValidF}, 32'd0);
        check("mrst_req", {31'd0, bus.inst_req}, 32'd0);
        tick();
        bus.inst_data_ok = 1'b0;
        check("mrst_ign_valid", {31'd0, InstValidF}, 32'd0);
        check("mrst_ign_rdata", ReadDataF, 32'd0);
        check("mrst_req2", {31'd0, bus.inst_req}, 32'd1);
        check("mrst_addr2", bus.inst_addr, 32'hBFC0_0000);

        // PC+4 wraps modulo 2^32.
        BranchRedirectD = 1'b1;
        BranchTargetD = 32'hFFFF_FFFC;
        tick();
        BranchRedirectD = 1'b0;
        check("wrap_pc", PCF, 32'hFFFF_FFFC);
        check("wrap_pc4", PCPlus4F, 32'h0000_0000);

        check("no_stale", {31'd0, r_saw_stale}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
